// File: rtl/serial_add_pkg.sv
// Shared types and defaults for the bit-serial adder scheduler and its engine.
package serial_add_pkg;

    localparam int D_WIDTH_DEF = 8;
    localparam int D_WID_4_DEF = 4;
    localparam int ID_W        = 1;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

endpackage

// File: rtl/serial_add_engine.sv
// Bit-serial ripple adder: A/B/sum shift registers, Mealy carry flop and bit counter.
// Optional overflow flag is built when SERIAL_ADD_OVF_EN is defined.
module serial_add_engine
    import serial_add_pkg::*;
#(
    parameter int D_WIDTH = D_WIDTH_DEF,
    parameter int D_WID_4 = D_WID_4_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic               shift,
    input  logic [D_WIDTH-1:0] a,
    input  logic [D_WIDTH-1:0] b,
    output logic [D_WIDTH-1:0] sum,
    output logic               cout,
    output logic               carry,
    output logic [D_WID_4-1:0] count,
    output logic               last
`ifdef SERIAL_ADD_OVF_EN
    ,
    output logic               ovf
`endif
);

    localparam logic [D_WID_4-1:0] LAST_IDX = D_WID_4'(D_WIDTH - 1);

    logic [D_WIDTH-1:0] a_reg;
    logic [D_WIDTH-1:0] b_reg;
    logic [D_WIDTH-1:0] sum_reg;
    logic               carry_reg;
    logic [D_WID_4-1:0] count_reg;
    logic               s_bit;
    logic               carry_next;

    assign s_bit      = a_reg[0] ^ b_reg[0] ^ carry_reg;
    assign carry_next = (a_reg[0] & b_reg[0]) | (a_reg[0] & carry_reg) | (b_reg[0] & carry_reg);
    assign last       = (count_reg == LAST_IDX);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_reg     <= '0;
            b_reg     <= '0;
            sum_reg   <= '0;
            carry_reg <= 1'b0;
            count_reg <= '0;
        end else if (load) begin
            a_reg     <= a;
            b_reg     <= b;
            sum_reg   <= '0;
            carry_reg <= 1'b0;
            count_reg <= '0;
        end else if (shift) begin
            a_reg     <= a_reg >> 1;
            b_reg     <= b_reg >> 1;
            sum_reg   <= {s_bit, sum_reg[D_WIDTH-1:1]};
            carry_reg <= carry_next;
            // Counter parks on the last index so it can never wrap.
            if (!last) begin
                count_reg <= count_reg + 1'b1;
            end
        end
    end

`ifdef SERIAL_ADD_OVF_EN
    logic ovf_reg;

    // On the MSB cycle, carry_reg is the carry into the MSB and carry_next the carry out.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovf_reg <= 1'b0;
        end else if (load) begin
            ovf_reg <= 1'b0;
        end else if (shift && last) begin
            ovf_reg <= carry_reg ^ carry_next;
        end
    end

    assign ovf = ovf_reg;
`endif

    assign sum   = sum_reg;
    assign cout  = carry_reg;
    assign carry = carry_reg;
    assign count = count_reg;

endmodule

// File: rtl/serial_add_sched.sv
// Round-robin scheduler sharing one serial-add engine between two requesters.
// Define SERIAL_ADD_OVF_EN to add the resp_ovf two's-complement overflow output.
module serial_add_sched
    import serial_add_pkg::*;
#(
    parameter int D_WIDTH = D_WIDTH_DEF,
    parameter int D_WID_4 = D_WID_4_DEF
) (
    input  logic               i_clk,
    input  logic               reset,
    input  logic               req0_valid,
    input  logic [D_WIDTH-1:0] req0_a,
    input  logic [D_WIDTH-1:0] req0_b,
    output logic               req0_ready,
    input  logic               req1_valid,
    input  logic [D_WIDTH-1:0] req1_a,
    input  logic [D_WIDTH-1:0] req1_b,
    output logic               req1_ready,
    output logic               resp_valid,
    input  logic               resp_ready,
    output logic               resp_id,
    output logic [D_WIDTH-1:0] resp_sum,
    output logic               resp_cout,
    output logic               p_STATE,
    output logic [D_WID_4-1:0] Count_out,
    output logic               busy
`ifdef SERIAL_ADD_OVF_EN
    ,
    output logic               resp_ovf
`endif
);

    state_t            state_reg;
    state_t            state_next;
    logic              rr_reg;      // 1: req1 wins a tie
    logic [ID_W-1:0]   id_reg;
    logic              grant0;
    logic              grant1;
    logic              accept;
    logic              load;
    logic              shift;
    logic [D_WIDTH-1:0] sel_a;
    logic [D_WIDTH-1:0] sel_b;
    logic [D_WIDTH-1:0] sum;
    logic              cout;
    logic              carry;
    logic [D_WID_4-1:0] count;
    logic              last;

    assign grant0     = req0_valid & (~req1_valid | ~rr_reg);
    assign grant1     = req1_valid & (~req0_valid |  rr_reg);
    assign req0_ready = (state_reg == IDLE) & grant0;
    assign req1_ready = (state_reg == IDLE) & grant1;
    assign accept     = req0_ready | req1_ready;
    assign sel_a      = grant1 ? req1_a : req0_a;
    assign sel_b      = grant1 ? req1_b : req0_b;

    always_ff @(posedge i_clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            rr_reg    <= 1'b0;
            id_reg    <= '0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                id_reg <= ID_W'(grant1);
                rr_reg <= ~grant1;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        load       = 1'b0;
        shift      = 1'b0;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    load       = 1'b1;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                shift = 1'b1;
                if (last) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (resp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    serial_add_engine #(
        .D_WIDTH (D_WIDTH),
        .D_WID_4 (D_WID_4)
    ) u_engine (
        .clk   (i_clk),
        .reset (reset),
        .load  (load),
        .shift (shift),
        .a     (sel_a),
        .b     (sel_b),
        .sum   (sum),
        .cout  (cout),
        .carry (carry),
        .count (count),
        .last  (last)
`ifdef SERIAL_ADD_OVF_EN
        ,
        .ovf   (resp_ovf)
`endif
    );

    assign resp_valid = (state_reg == DONE);
    assign resp_id    = id_reg[0];
    assign resp_sum   = sum;
    assign resp_cout  = cout;
    assign p_STATE    = carry;
    assign Count_out  = count;
    assign busy       = (state_reg != IDLE);

endmodule

// File: tb/tb_serial_add_sched.sv
// Self-checking bench for serial_add_sched against an arithmetic reference model.
// Checks resp_ovf as well when SERIAL_ADD_OVF_EN is defined.
module tb_serial_add_sched;

    localparam int D = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         req0_valid, req1_valid, resp_ready;
    logic [D-1:0] req0_a, req0_b, req1_a, req1_b;
    logic         req0_ready, req1_ready, resp_valid, resp_id, resp_cout, p_STATE, busy;
    logic [D-1:0] resp_sum;
    logic [3:0]   Count_out;
`ifdef SERIAL_ADD_OVF_EN
    logic         resp_ovf;
`endif

    serial_add_sched dut (
        .i_clk      (clk),
        .reset      (rst),
        .req0_valid (req0_valid),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_ready (req1_ready),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_id    (resp_id),
        .resp_sum   (resp_sum),
        .resp_cout  (resp_cout),
        .p_STATE    (p_STATE),
        .Count_out  (Count_out),
        .busy       (busy)
`ifdef SERIAL_ADD_OVF_EN
        ,
        .resp_ovf   (resp_ovf)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;
    int tb_prio  = 0;     // requester that wins a tie
    bit have_prev = 0;
    int prev_acc, prev_stall;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Carry out of the low k bits of a+b.
    function automatic logic carry_after(input logic [D-1:0] a, input logic [D-1:0] b, input int k);
        int m;
        m = (1 << k) - 1;
        return 1'(((int'(a) & m) + (int'(b) & m)) >> k);
    endfunction

    task automatic txn(input bit v0, input bit v1,
                       input logic [D-1:0] a0, input logic [D-1:0] b0,
                       input logic [D-1:0] a1, input logic [D-1:0] b1,
                       input int stall, input bit keep);
        int g, acc;
        logic [D-1:0] ea, eb;
        logic [D:0]   full;
        g    = (v0 && !v1) ? 0 : ((v1 && !v0) ? 1 : tb_prio);
        ea   = (g == 1) ? a1 : a0;
        eb   = (g == 1) ? b1 : b0;
        full = {1'b0, ea} + {1'b0, eb};
        req0_valid = v0; req0_a = a0; req0_b = b0;
        req1_valid = v1; req1_a = a1; req1_b = b1;
        resp_ready = 1'b0;
        #1;
        chk("req0_ready_grant", req0_ready, g == 0);
        chk("req1_ready_grant", req1_ready, g == 1);
        acc = cyc;
        if (have_prev) chk("accept_spacing", acc - prev_acc, D + 2 + prev_stall);
        @(posedge clk); #1;
        tb_prio = 1 - g;
        req0_a = D'($urandom); req0_b = D'($urandom);
        req1_a = D'($urandom); req1_b = D'($urandom);
        if (!keep) begin
            if (g == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
        end
        #1;
        for (int k = 0; k < D; k++) begin
            chk("shift_resp_valid", resp_valid, 0);
            chk("shift_busy", busy, 1);
            chk("shift_ready", {req0_ready, req1_ready}, 0);
            chk("count_out", Count_out, k);
            chk("p_state", p_STATE, carry_after(ea, eb, k));
            @(posedge clk); #2;
        end
        for (int s = 0; s <= stall; s++) begin
            if (s == 0) chk("latency", cyc - acc, D + 1);
            chk("done_resp_valid", resp_valid, 1);
            chk("done_ready", {req0_ready, req1_ready}, 0);
            chk("resp_sum", resp_sum, full[D-1:0]);
            chk("resp_cout", resp_cout, full[D]);
            chk("resp_id", resp_id, g);
`ifdef SERIAL_ADD_OVF_EN
            chk("resp_ovf", resp_ovf, (ea[D-1] == eb[D-1]) && (full[D-1] != ea[D-1]));
`endif
            if (s == stall) resp_ready = 1'b1;
            @(posedge clk); #2;
        end
        resp_ready = 1'b0;
        chk("post_resp_valid", resp_valid, 0);
        chk("post_busy", busy, 0);
        $display("txn grant=%0d a=%02h b=%02h sum=%02h cout=%0d stall=%0d", g, ea, eb, resp_sum, resp_cout, stall);
        prev_acc   = acc;
        prev_stall = stall;
        have_prev  = 1;
    endtask

    initial begin
        rst = 1'b1;
        req0_valid = 0; req1_valid = 0; resp_ready = 0;
        req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_busy", busy, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_sum", resp_sum, 0);
        chk("rst_resp_cout", resp_cout, 0);
        chk("rst_resp_id", resp_id, 0);
        chk("rst_count", Count_out, 0);
        chk("rst_carry", p_STATE, 0);
        chk("rst_ready", {req0_ready, req1_ready}, 0);
        rst = 1'b0;
        @(posedge clk); #2;

        // Directed cases
        txn(1, 0, 8'h08, 8'h08, 8'h00, 8'h00, 0, 0);
        txn(0, 1, 8'h00, 8'h00, 8'h18, 8'h0C, 0, 0);
        txn(1, 0, 8'hFF, 8'h01, 8'h00, 8'h00, 0, 0);
        txn(0, 1, 8'h00, 8'h00, 8'h7F, 8'h01, 0, 0);

        // Contention: both valid back-to-back, grants alternate
        for (int i = 0; i < 4; i++)
            txn(1, 1, D'($urandom), D'($urandom), D'($urandom), D'($urandom), 0, 1);

        // Backpressure
        txn(1, 1, D'($urandom), D'($urandom), D'($urandom), D'($urandom), 5, 1);

        // Random mix
        for (int i = 0; i < 8; i++) begin
            bit v0, v1;
            v0 = 1'($urandom);
            v1 = v0 ? 1'($urandom) : 1'b1;
            txn(v0, v1, D'($urandom), D'($urandom), D'($urandom), D'($urandom),
                int'($urandom_range(0, 3)), 1'($urandom));
        end

        // Leave req1 holding the tie priority, then abort mid-shift
        txn(1, 0, 8'h11, 8'h22, 8'h00, 8'h00, 0, 0);
        req0_valid = 1; req1_valid = 1; resp_ready = 0;
        @(posedge clk); #2;
        repeat (3) begin @(posedge clk); #2; end
        chk("pre_reset_count", Count_out, 3);
        chk("pre_reset_busy", busy, 1);
        rst = 1'b1; req0_valid = 0; req1_valid = 0;
        #1;
        chk("async_rst_busy", busy, 0);
        chk("async_rst_resp_valid", resp_valid, 0);
        chk("async_rst_count", Count_out, 0);
        chk("async_rst_carry", p_STATE, 0);
        repeat (3) begin
            @(posedge clk); #2;
            chk("in_rst_resp_valid", resp_valid, 0);
            chk("in_rst_busy", busy, 0);
        end
        rst = 1'b0;
        tb_prio   = 0;
        have_prev = 0;
        @(posedge clk); #2;
        chk("post_rst_resp_valid", resp_valid, 0);
        txn(1, 1, 8'h80, 8'h80, 8'h01, 8'h02, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
